// File: rtl/mem_map_pkg.sv
// -----------------------------------------------------------------------------
// mem_map_pkg
// Shared address-map constants and the UART transmitter state type for the
// memory responder and its UART core.
//   IO_BIT          : address bit that selects the IO page instead of RAM
//   IO_LEDS/...     : one-hot register select codes taken from mem_addr[4:2]
//   UART_BUSY_BIT   : bit position of the busy flag in the UART status word
//   uart_state_e    : UART transmitter frame states
// -----------------------------------------------------------------------------
package mem_map_pkg;

   localparam int IO_BIT = 22;

   localparam logic [2:0] IO_LEDS        = 3'b001;
   localparam logic [2:0] IO_UART_DATA   = 3'b010;
   localparam logic [2:0] IO_UART_STATUS = 3'b100;

   localparam int UART_BUSY_BIT = 9;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;

   // Clock cycles per UART bit period.
   function automatic int baud_divisor(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// 8N1 UART transmitter, LSB first. A byte is accepted when valid is high and
// busy is low; the frame (start, 8 data bits, stop) is then shifted out with
// one bit period of CLK_FREQ_HZ/BAUD clocks per bit.
//
// busy is high from the cycle after acceptance until the last clock of the
// stop bit. In that last clock busy is already low, so a byte offered there is
// accepted and its start bit follows the stop bit with no idle gap.
//
// Optional build macro UART_SIM_PRINT_EN: the serial engine is removed, every
// offered byte is printed with $write, busy stays 0 and tx stays 1.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high; aborts any frame in progress
//   data   in   byte to transmit
//   valid  in   offer data this cycle
//   busy   out  transmitter cannot accept a byte
//   tx     out  serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_core
   import mem_map_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD        = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       busy,
   output logic       tx
);

   localparam int DIV = baud_divisor(CLK_FREQ_HZ, BAUD);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("uart_tx_core: CLK_FREQ_HZ/BAUD must be at least 2");
   end

`ifdef UART_SIM_PRINT_EN

   assign busy = 1'b0;
   assign tx   = 1'b1;

   always_ff @(posedge clk) begin
      if (valid) begin
         $write("%c", data);
      end
   end

`else

   uart_state_e     state_reg;
   logic [CW-1:0]   baud_cnt_reg;
   logic [2:0]      bit_idx_reg;
   logic [7:0]      shift_reg;
   logic            busy_reg;
   logic            tx_reg;

   assign busy = busy_reg;
   assign tx   = tx_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= UART_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         busy_reg     <= 1'b0;
         tx_reg       <= 1'b1;
      end else if (valid && !busy_reg) begin
         // Accept: covers both IDLE and the final stop-bit clock.
         state_reg    <= UART_START;
         baud_cnt_reg <= CNT_RELOAD;
         bit_idx_reg  <= '0;
         shift_reg    <= data;
         busy_reg     <= 1'b1;
         tx_reg       <= 1'b0;
      end else begin
         case (state_reg)
            UART_IDLE: begin
               tx_reg <= 1'b1;
            end
            UART_START: begin
               if (baud_cnt_reg == '0) begin
                  state_reg    <= UART_DATA;
                  baud_cnt_reg <= CNT_RELOAD;
                  tx_reg       <= shift_reg[0];
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 1'b1;
               end
            end
            UART_DATA: begin
               if (baud_cnt_reg == '0) begin
                  baud_cnt_reg <= CNT_RELOAD;
                  if (bit_idx_reg == 3'd7) begin
                     state_reg <= UART_STOP;
                     tx_reg    <= 1'b1;
                  end else begin
                     // The next bit to send sits one position up.
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                     tx_reg      <= shift_reg[1];
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 1'b1;
               end
            end
            UART_STOP: begin
               if (baud_cnt_reg == '0) begin
                  state_reg <= UART_IDLE;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 1'b1;
                  // Drop busy one clock early so a waiting byte can chain.
                  if (baud_cnt_reg == CW'(1)) begin
                     busy_reg <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg <= UART_IDLE;
               busy_reg  <= 1'b0;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

`endif

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Responder side of the processor's single-port memory bus. Serves a
// byte-maskable word RAM and a small IO page (LEDs, UART data, UART status).
//
// Address map:
//   mem_addr[22] = 0 : RAM, word index mem_addr[31:2] modulo MEM_WORDS
//   mem_addr[22] = 1 : IO page, one-hot register select on mem_addr[4:2]
//                      001 LEDs, 010 UART data, 100 UART status (busy at bit 9)
// Reads have exactly one cycle of latency and mem_rdata holds until the next
// strobe. A read and write in the same cycle returns the pre-write contents.
//
// Optional build macro UART_SIM_PRINT_EN (see uart_tx_core): UART bytes are
// printed in simulation instead of being serialised.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high (RAM contents are not reset)
//   mem_addr   in   byte address
//   mem_rstrb  in   read strobe
//   mem_wdata  in   write data, lane-replicated by the processor
//   mem_wmask  in   byte write enables, nonzero means write
//   mem_rdata  out  registered read data
//   leds       out  LED register
//   uart_tx    out  UART serial line
// -----------------------------------------------------------------------------
module mem_responder
   import mem_map_pkg::*;
#(
   parameter int    MEM_WORDS   = 1536,
   parameter string INIT_FILE   = "",
   parameter int    CLK_FREQ_HZ = 12000000,
   parameter int    BAUD        = 115200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic        mem_rstrb,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   output logic [31:0] mem_rdata,
   output logic [4:0]  leds,
   output logic        uart_tx
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   // ---------------------------------------------------------------- decode
   logic          io_sel;
   logic [2:0]    io_reg;
   logic          wr_en;
   logic [29:0]   word_addr;
   logic [AW-1:0] word_idx;
   logic          unused_addr_bits;

   assign io_sel    = mem_addr[IO_BIT];
   assign io_reg    = mem_addr[4:2];
   assign wr_en     = |mem_wmask;
   assign word_addr = mem_addr[31:2];
   // Out-of-range addresses wrap instead of faulting.
   assign word_idx  = AW'(word_addr % 30'(MEM_WORDS));
   assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

   // ---------------------------------------------------------------- RAM
   logic [31:0] ram [0:MEM_WORDS-1];
   logic [31:0] rd_ram_reg;

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) begin
         ram[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !io_sel) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wmask[i]) begin
               ram[word_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
         end
      end
   end

   // Plain registered read so the array maps onto block RAM; non-blocking
   // semantics give read-before-write on a same-cycle write.
   always_ff @(posedge clk) begin
      if (mem_rstrb) begin
         rd_ram_reg <= ram[word_idx];
      end
   end

   // ---------------------------------------------------------------- IO page
   logic [4:0]  leds_reg;
   logic        uart_valid;
   logic        uart_busy;
   logic [31:0] io_rdata;

   assign leds       = leds_reg;
   assign uart_valid = wr_en && io_sel && (io_reg == IO_UART_DATA);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         leds_reg <= '0;
      end else if (wr_en && io_sel && (io_reg == IO_LEDS)) begin
         leds_reg <= mem_wdata[4:0];
      end
   end

   always_comb begin
      io_rdata = '0;
      case (io_reg)
         IO_LEDS:        io_rdata[4:0]         = leds_reg;
         IO_UART_STATUS: io_rdata[UART_BUSY_BIT] = uart_busy;
         default:        io_rdata              = '0;
      endcase
   end

   uart_tx_core #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD)
   ) u_uart_tx (
      .clk   (clk),
      .reset (reset),
      .data  (mem_wdata[7:0]),
      .valid (uart_valid),
      .busy  (uart_busy),
      .tx    (uart_tx)
   );

   // ---------------------------------------------------------------- read mux
   // IO data and the source select are reset so mem_rdata reads 0 after reset
   // even though the RAM output register is never reset.
   logic [31:0] rd_io_reg;
   logic        rd_from_ram_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_io_reg       <= '0;
         rd_from_ram_reg <= 1'b0;
      end else if (mem_rstrb) begin
         rd_io_reg       <= io_rdata;
         rd_from_ram_reg <= !io_sel;
      end
   end

   assign mem_rdata = rd_from_ram_reg ? rd_ram_reg : rd_io_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic [31:0] mem_rdata;
   logic [4:0]  leds;
   logic        uart_tx;

   mem_responder #(
      .MEM_WORDS   (4),
      .INIT_FILE   (""),
      .CLK_FREQ_HZ (400),
      .BAUD        (100)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_rstrb (mem_rstrb),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata),
      .leds      (leds),
      .uart_tx   (uart_tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;   // number of rising edges so far

   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------ reference model
   logic [31:0] ram_m [4];
   logic [4:0]  leds_m = '0;
   int          fr_start = -1000;   // edge at which the current frame was accepted
   logic [7:0]  fr_byte = '0;
   logic [31:0] exp_q [$];
   logic [31:0] last_exp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Busy as seen after edge c: a frame lasts 40 clocks, busy for the first 39.
   function automatic logic m_busy(input int c);
      int d;
      d = c - fr_start;
      return (d >= 0) && (d <= 38);
   endfunction

   // Serial line after edge c: start, 8 data bits LSB first, stop; 4 clocks each.
   function automatic logic m_tx(input int c);
      int d;
      int b;
      d = c - fr_start;
      if (d < 0 || d >= 40) return 1'b1;
      b = d / 4;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return fr_byte[b-1];
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input int c);
      if (a[22]) begin
         case (a[4:2])
            3'b001:  return {27'b0, leds_m};
            3'b100:  return 32'(m_busy(c)) << 9;
            default: return 32'h0;
         endcase
      end
      return ram_m[(a >> 2) % 4];
   endfunction

   // One bus cycle: inputs presented at the falling edge, committed at the next rising edge.
   task automatic op(input logic [31:0] a, input logic rs, input logic [31:0] wd,
                     input logic [3:0] wm);
      int e;
      string note;
      @(negedge clk);
      mem_addr  = a;
      mem_rstrb = rs;
      mem_wdata = wd;
      mem_wmask = wm;
      e = cyc + 1;
      note = "";
      if (rs) exp_q.push_back(m_read(a, e - 1));
      if (wm != 4'b0) begin
         if (!a[22]) begin
            for (int i = 0; i < 4; i++)
               if (wm[i]) ram_m[(a >> 2) % 4][i*8 +: 8] = wd[i*8 +: 8];
         end else begin
            case (a[4:2])
               3'b001: leds_m = wd[4:0];
               3'b010: begin
                  if (!m_busy(e - 1)) begin
                     fr_start = e;
                     fr_byte  = wd[7:0];
                     note = " uart accepted";
                  end else begin
                     note = " uart dropped";
                  end
               end
               default: ;
            endcase
         end
      end
      if (rs || wm != 4'b0)
         $display("op cyc=%0d addr=%08h rstrb=%0b wdata=%08h wmask=%04b%s",
                  e, a, rs, wd, wm, note);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(32'h0, 1'b0, 32'h0, 4'b0);
   endtask

   // ------------------------------------------------ monitors
   initial begin : rd_mon
      logic s;
      forever begin
         @(posedge clk);
         s = mem_rstrb && !reset;
         #1;
         if (reset) begin
            last_exp = '0;
         end else if (s) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rdata_queue: got %08h expected no read (cycle %0d)", mem_rdata, cyc);
            end else begin
               last_exp = exp_q.pop_front();
               check("mem_rdata", mem_rdata, last_exp);
            end
         end else begin
            check("rdata_hold", mem_rdata, last_exp);
         end
      end
   end

   initial begin : tx_mon
      forever begin
         @(posedge clk);
         #1;
         if (!reset) check("uart_tx", 32'(uart_tx), 32'(m_tx(cyc)));
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------ stimulus
   initial begin
      logic [31:0] a;
      int k;

      repeat (3) @(negedge clk);
      check("reset_rdata", mem_rdata, 32'h0);
      check("reset_leds", 32'(leds), 32'h0);
      check("reset_tx", 32'(uart_tx), 32'h1);
      reset = 1'b0;

      // Preload all words so no read ever sees uninitialised RAM.
      op(32'h0, 1'b0, 32'h0BAD_0000, 4'hF);
      op(32'h4, 1'b0, 32'h1111_2222, 4'hF);
      op(32'h8, 1'b0, 32'h3333_4444, 4'hF);
      op(32'hC, 1'b0, 32'hDEAD_BEEF, 4'hF);

      op(32'hC, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("word3_read", mem_rdata, 32'hDEADBEEF);
      idle(3);
      check("word3_held", mem_rdata, 32'hDEADBEEF);

      op(32'hC, 1'b0, 32'h00AA_0000, 4'b0100);
      op(32'hC, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("byte_write", mem_rdata, 32'hDEAABEEF);

      op(32'hC, 1'b0, 32'h1234_1234, 4'b1100);
      op(32'hC, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("half_write", mem_rdata, 32'h1234BEEF);

      op(32'hC, 1'b1, 32'hCAFE_F00D, 4'hF);
      idle(1);
      check("read_before_write", mem_rdata, 32'h1234BEEF);
      op(32'hC, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("after_rbw", mem_rdata, 32'hCAFEF00D);

      op(32'h18, 1'b0, 32'h5A5A_0002, 4'hF);
      op(32'h08, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("alias_word2", mem_rdata, 32'h5A5A0002);

      op(32'h0040_0004, 1'b0, 32'h0000_001F, 4'h1);
      idle(1);
      check("leds_write", 32'(leds), 32'h1F);
      op(32'h0040_0004, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("leds_read", mem_rdata, 32'h0000001F);

      // Frame 0x41, status while busy, dropped write, status after the frame.
      op(32'h0040_0008, 1'b0, 32'h0000_0041, 4'h1);
      idle(8);
      op(32'h0040_0010, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("status_busy", mem_rdata, 32'h00000200);
      op(32'h0040_0008, 1'b0, 32'h0000_007E, 4'h1);
      idle(40);
      op(32'h0040_0010, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("status_idle", mem_rdata, 32'h0);

      // Second byte offered in the final stop-bit clock chains with no gap.
      op(32'h0040_0008, 1'b0, 32'h0000_0055, 4'h1);
      idle(39);
      op(32'h0040_0008, 1'b0, 32'h0000_00A3, 4'h1);
      idle(1);
      check("b2b_start_bit", 32'(uart_tx), 32'h0);
      idle(45);

      // Reset during data bit 3 of 0xC3 (bit 3 = 0).
      op(32'h0040_0008, 1'b0, 32'h0000_00C3, 4'h1);
      idle(17);
      check("pre_reset_tx", 32'(uart_tx), 32'h0);
      reset = 1'b1;
      fr_start = -1000;
      leds_m = '0;
      #1;
      check("async_reset_tx", 32'(uart_tx), 32'h1);
      check("async_reset_leds", 32'(leds), 32'h0);
      check("async_reset_rdata", mem_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      op(32'h0040_0010, 1'b1, 32'h0, 4'h0);
      idle(1);
      check("busy_after_reset", mem_rdata, 32'h0);

      // Randomised traffic against the model.
      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2, 3: begin
               a = $urandom & 32'hFFBF_FFFF;
               op(a, 1'($urandom), $urandom, 4'($urandom));
            end
            4: begin
               a = ($urandom & 32'hFFFF_FFE3) | 32'h0040_0004;
               op(a, 1'($urandom), $urandom, 4'($urandom));
            end
            5: begin
               a = ($urandom & 32'hFFFF_FFE3) | 32'h0040_0008;
               op(a, 1'($urandom), $urandom, 4'($urandom_range(1, 15)));
            end
            6: begin
               a = ($urandom & 32'hFFFF_FFE3) | 32'h0040_0010;
               op(a, 1'b1, $urandom, 4'($urandom));
            end
            7: begin
               case ($urandom_range(0, 4))
                  0: a = 32'h0040_0000;
                  1: a = 32'h0040_000C;
                  2: a = 32'h0040_0014;
                  3: a = 32'h0040_0018;
                  default: a = 32'h0040_001C;
               endcase
               op(a, 1'($urandom), $urandom, 4'($urandom));
            end
            default: idle($urandom_range(0, 5));
         endcase
      end

      idle(60);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
